// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - iterative binary-to-BCD converter (shift-add-3, one bit per cycle)
//
// Converts an unsigned (or, with BIN2BCD_SIGNED_EN, two's complement) binary
// operand into packed BCD. One operand bit is consumed per clock. The
// start/busy/val handshake matches the upstream divider, so a conversion can
// be launched directly from the divider's val pulse.
//
// Optional build macro: BIN2BCD_SIGNED_EN
//   defined   - x is two's complement; |x| is converted and neg carries the sign
//   undefined - x is unsigned; neg is tied 0
//
// Parameters:
//   WIDTH   width of binary operand x
//   DIGITS  number of BCD digits produced (must cover 2**WIDTH-1)
//
// Ports:
//   clk    in   1         clock, rising edge
//   rst    in   1         asynchronous reset, active low
//   start  in   1         request conversion of x (accepted only when idle)
//   x      in   WIDTH     binary operand
//   busy   out  1         conversion in progress
//   val    out  1         bcd holds a valid result
//   bcd    out  4*DIGITS  packed BCD result, digit 0 in bits [3:0]
//   neg    out  1         sign of the converted operand

module bin2bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      x,
  output logic                  busy,
  output logic                  val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // ------------------------------------------------------------------
  // Elaboration-time range check: DIGITS must hold the largest operand.
  // ------------------------------------------------------------------
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  localparam longint unsigned X_MAX = (longint'(1) << WIDTH) - 1;

  if (pow10(DIGITS) <= X_MAX) begin : g_range_check
    $fatal(1, "bin2bcd: DIGITS too small for WIDTH");
  end

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [WIDTH-1:0] sr;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             done;
  logic [WIDTH-1:0] x_mag;
  logic [AW-1:0]    acc_adj;
  logic [AW+WIDTH-1:0] both_shift;

  // Operand magnitude latched on the start edge.
`ifdef BIN2BCD_SIGNED_EN
  // Negating the most negative value wraps back to itself, which read as
  // unsigned is exactly its magnitude 2**(WIDTH-1).
  assign x_mag = x[WIDTH-1] ? (~x) + WIDTH'(1) : x;
`else
  assign x_mag = x;
`endif

  // Add 3 to every digit that is 5 or more. Digits never exceed 9 before
  // the adjust, so each digit stays within 4 bits and no carry ripples.
  function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign acc_adj    = add3(acc);
  // The bit shifted out of the accumulator top is always zero given the
  // range check, so it is simply dropped.
  assign both_shift = {acc_adj, sr} << 1;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // ------------------------------------------------------------------
  always_comb begin
    busy   = 1'b0;
    accept = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
      end
      SHIFT: begin
        busy = 1'b1;
        done = (cnt == CW'(1));
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
      bcd <= '0;
      val <= 1'b0;
    end else if (accept) begin
      sr  <= x_mag;
      acc <= '0;
      cnt <= CW'(WIDTH);
      val <= 1'b0;
    end else if (busy) begin
      sr  <= both_shift[WIDTH-1:0];
      acc <= both_shift[AW+WIDTH-1:WIDTH];
      cnt <= cnt - CW'(1);
      if (done) begin
        bcd <= both_shift[AW+WIDTH-1:WIDTH];
        val <= 1'b1;
      end
    end
  end

  // Sign output: updated together with the operand latch, so it is cleared
  // (or set) on the same accepted start that drops val.
`ifdef BIN2BCD_SIGNED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= x[WIDTH-1];
    end
  end
`else
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd.sv
// tb/tb_bin2bcd.sv - directed self-checking bench for bin2bcd

module tb_bin2bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  x;
  logic        busy;
  logic        val;
  logic [11:0] bcd;
  logic        neg;

  int vectors;
  int errors;

  bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .busy  (busy),
    .val   (val),
    .bcd   (bcd),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-tick start; returns at the falling edge after the start edge.
  task automatic launch(input logic [7:0] v);
    @(negedge clk);
    start = 1'b1;
    x     = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    start = 1'b0;
    x     = 8'h00;
    #23;
    vectors++;
    if (busy !== 1'b0 || val !== 1'b0 || bcd !== 12'h000 || neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b val=%b bcd=%h neg=%b, want 0 0 000 0", busy, val, bcd, neg);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_max;
    launch(8'd255);
    x = 8'h00;  // operand may change after the start edge
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (busy !== 1'b1 || val !== 1'b0) begin
        errors++;
        $display("FAIL max_busy[%0d]: busy=%b val=%b, want 1 0", i, busy, val);
      end
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (val !== 1'b1 || busy !== 1'b0 || bcd !== 12'h255) begin
      errors++;
      $display("FAIL max_result: val=%b busy=%b bcd=%h, want 1 0 255", val, busy, bcd);
    end
    wait_edges(3);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h255) begin
      errors++;
      $display("FAIL max_hold: val=%b bcd=%h, want 1 255", val, bcd);
    end
  endtask

  task automatic test_zero_then_eleven;
    launch(8'd0);
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h000) begin
      errors++;
      $display("FAIL zero_result: val=%b bcd=%h, want 1 000", val, bcd);
    end
    launch(8'd11);
    vectors++;
    if (val !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL eleven_start: val=%b busy=%b, want 0 1", val, busy);
    end
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h011) begin
      errors++;
      $display("FAIL eleven_result: val=%b bcd=%h, want 1 011", val, bcd);
    end
  endtask

  task automatic test_start_while_busy;
    launch(8'd200);
    wait_edges(3);
    start = 1'b1;
    x     = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_edges(3);
    vectors++;
    if (val !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_pending: val=%b busy=%b, want 0 1", val, busy);
    end
    wait_edges(1);
    vectors++;
    if (val !== 1'b1 || busy !== 1'b0 || bcd !== 12'h200) begin
      errors++;
      $display("FAIL busy_ignore_result: val=%b busy=%b bcd=%h, want 1 0 200", val, busy, bcd);
    end
  endtask

  task automatic test_async_reset;
    launch(8'd99);
    wait_edges(4);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || val !== 1'b0 || bcd !== 12'h000 || neg !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b val=%b bcd=%h neg=%b, want 0 0 000 0", busy, val, bcd, neg);
    end
    @(negedge clk);
    rst = 1'b1;
    launch(8'd42);
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h042) begin
      errors++;
      $display("FAIL after_reset: val=%b bcd=%h, want 1 042", val, bcd);
    end
  endtask

  // Divider stand-in: q and r of 11/3 are fed back to back with start held.
  task automatic test_chain_back_to_back;
    logic [7:0] q;
    logic [7:0] r;
    q = 8'd11 / 8'd3;
    r = 8'd11 % 8'd3;
    @(negedge clk);
    start = 1'b1;
    x     = q;
    @(posedge clk);
    @(negedge clk);
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || busy !== 1'b0 || bcd !== 12'h003) begin
      errors++;
      $display("FAIL chain_q: val=%b busy=%b bcd=%h, want 1 0 003", val, busy, bcd);
    end
    x = r;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (val !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL chain_relaunch: val=%b busy=%b, want 0 1", val, busy);
    end
    start = 1'b0;
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h002) begin
      errors++;
      $display("FAIL chain_r: val=%b bcd=%h, want 1 002", val, bcd);
    end
  endtask

  task automatic test_sign;
    logic [11:0] exp_bcd;
    logic        exp_neg;
`ifdef BIN2BCD_SIGNED_EN
    exp_bcd = 12'h008;
    exp_neg = 1'b1;
`else
    exp_bcd = 12'h248;
    exp_neg = 1'b0;
`endif
    launch(8'hF8);
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== exp_bcd || neg !== exp_neg) begin
      errors++;
      $display("FAIL sign_f8: val=%b bcd=%h neg=%b, want 1 %h %b", val, bcd, neg, exp_bcd, exp_neg);
    end
    launch(8'h80);
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h128 || neg !== exp_neg) begin
      errors++;
      $display("FAIL sign_80: val=%b bcd=%h neg=%b, want 1 128 %b", val, bcd, neg, exp_neg);
    end
    launch(8'd5);
    vectors++;
    if (neg !== 1'b0 || val !== 1'b0) begin
      errors++;
      $display("FAIL sign_clear: neg=%b val=%b, want 0 0", neg, val);
    end
    wait_edges(8);
    vectors++;
    if (val !== 1'b1 || bcd !== 12'h005 || neg !== 1'b0) begin
      errors++;
      $display("FAIL sign_pos: val=%b bcd=%h neg=%b, want 1 005 0", val, bcd, neg);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset;
    test_max;
    test_zero_then_eleven;
    test_start_while_busy;
    test_async_reset;
    test_chain_back_to_back;
    test_sign;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
